lsm_sequencer: RTL and testbench
================================

// Module: lsm_sequencer
// PURPOSE
//  Multi-cycle sequencer for ARM load/store-multiple (LDM/STM) execution. Started by the control
//  unit once the addressing-mode encoder selects the LSM path. Walks the register list, drives one
//  memory access per listed register using the MFA/MOC-style handshake (mem_req/mem_done), then
//  reports the base writeback value. Supports all four modes: IA, IB, DA and DB.
// PARAMETERS
//  DATA_W     32  address/data width
//  REG_CNT    16  register-list width (one bit per register)
//  REG_IDX_W   4  register index width; must satisfy 2**REG_IDX_W >= REG_CNT
// PORTS
//  clk         in   1          system clock, rising edge
//  reset       in   1          synchronous, active-high
//  start       in   1          launch request; sampled only in IDLE
//  reg_list    in   REG_CNT    register list (IR[15:0]); latched on an accepted start
//  base_addr   in   DATA_W     Rn contents; latched on an accepted start
//  rn_idx      in   REG_IDX_W  Rn index; latched on an accepted start
//  p_bit       in   1          IR[24]; 1 = before (IB/DB), 0 = after (IA/DA)
//  u_bit       in   1          IR[23]; 1 = up, 0 = down
//  w_bit       in   1          IR[21]; writeback requested
//  l_bit       in   1          IR[20]; 1 = load, 0 = store
//  mem_done    in   1          memory operation complete; honoured only in ACCESS
//  busy        out  1          1 whenever state != IDLE
//  mem_req     out  1          memory access request (MFA)
//  mem_rw      out  1          1 = read (load), 0 = write; equals the latched l_bit
//  mem_addr    out  DATA_W     word address of the current transfer
//  reg_idx     out  REG_IDX_W  register being transferred
//  reg_we      out  1          1-cycle pulse: load data for reg_idx is to be written to the register file
//  done        out  1          1-cycle pulse at end of instruction
//  wb_en       out  1          write wb_value to Rn; valid with done
//  wb_value    out  DATA_W     final base value
// BEHAVIOUR
//  - All outputs are registered. On reset: state = IDLE and every output = 0.
//  - Reset has priority over every other event, including mid-operation; no further mem_req is issued.
//  - FSM: IDLE -start-> SETUP -> ACCESS -mem_done-> NEXT -> ACCESS (bits remain) | DONE (none) -> IDLE.
//  - SETUP (1 cycle): n = popcount(reg_list). Start address (arithmetic modulo 2**DATA_W):
//      IA  base;   IB  base+4;   DA  base-4n+4;   DB  base-4n.
//    wb_value = U ? base+4n : base-4n.
//    If n == 0: go directly to DONE with no transfers and wb_value = base.
//  - ACCESS: mem_req = 1; reg_idx = lowest set bit remaining; mem_addr = current address.
//    Holds with no timeout until mem_done = 1.
//  - NEXT (1 cycle): mem_req = 0. reg_we = l_bit, with reg_idx still the completed register.
//    Clear that bit from the list; address += 4.
//  - Transfers are always issued in ascending register index with ascending addresses.
//  - Throughput: first mem_req 2 cycles after start; each transfer costs (mem_done wait) + 1 cycle.
//  - DONE (1 cycle): done = 1; wb_en = w_bit (see CONFIGURATION). Next cycle: IDLE, so start is
//    accepted again.
//  - start while busy is ignored. mem_done outside ACCESS is ignored.
// CONFIGURATION
//  LSM_BASE_LOAD_WINS_EN:
//    defined:   if l_bit = 1 and reg_list[rn_idx] = 1, wb_en = 0; the loaded value wins.
//    undefined: wb_en = w_bit unconditionally.
// TESTING
//  1. IA load: list=0x000F, base=0x100, P=0 U=1 W=1 L=1, mem_done 1 cycle after each req
//     -> addrs 0x100/0x104/0x108/0x10C; regs 0..3; 4 reg_we pulses; wb_en=1, wb_value=0x110.
//  2. DB store: list=0x8001, base=0x200, P=1 U=0 W=1 L=0
//     -> 0x1F8 (r0), 0x1FC (r15); reg_we never asserts; wb_value=0x1F8.
//  3. IB/DA with list=0x0110, base=0x40 -> IB: 0x44 (r4), 0x48 (r8); DA: 0x3C (r4), 0x40 (r8).
//  4. Empty list with start -> no mem_req; done 2 cycles after start; wb_value = base.
//  5. mem_done delayed 3 cycles, then reset asserted in a later ACCESS
//     -> mem_req held steady while waiting; all outputs 0 the cycle after reset.
//  6. Load list=0x0006 with rn_idx=2, W=1 -> wb_en=0 with LSM_BASE_LOAD_WINS_EN, 1 without.

Source files
------------

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks an ARM register list, issues one handshaked memory
// access per listed register and reports the base writeback value. Option: LSM_BASE_LOAD_WINS_EN.
module lsm_sequencer #(
    parameter int DATA_W    = 32,
    parameter int REG_CNT   = 16,
    parameter int REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [REG_CNT-1:0]   reg_list,
    input  logic [DATA_W-1:0]    base_addr,
    input  logic [REG_IDX_W-1:0] rn_idx,
    input  logic                 p_bit,
    input  logic                 u_bit,
    input  logic                 w_bit,
    input  logic                 l_bit,
    input  logic                 mem_done,
    output logic                 busy,
    output logic                 mem_req,
    output logic                 mem_rw,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [REG_IDX_W-1:0] reg_idx,
    output logic                 reg_we,
    output logic                 done,
    output logic                 wb_en,
    output logic [DATA_W-1:0]    wb_value
);

    // state  | meaning
    // IDLE   | waiting for start
    // SETUP  | count registers, compute start address and writeback value
    // ACCESS | mem_req held until mem_done
    // NEXT   | retire transfer, pulse reg_we on loads, advance address
    // DONE   | done pulse with writeback
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_NEXT,
        S_DONE
    } state_t;

`ifdef LSM_BASE_LOAD_WINS_EN
    localparam logic WINS_EN = 1'b1;
`else
    localparam logic WINS_EN = 1'b0;
`endif

    localparam logic [DATA_W-1:0] WORD = DATA_W'(4);

    state_t               state_q, state_d;
    logic [REG_CNT-1:0]   list_q, list_d;
    logic [DATA_W-1:0]    base_q, base_d;
    logic                 p_q, p_d;
    logic                 u_q, u_d;
    logic                 w_q, w_d;
    logic                 wins_q, wins_d;

    logic                 busy_d;
    logic                 mem_req_d;
    logic                 mem_rw_d;
    logic [DATA_W-1:0]    mem_addr_d;
    logic [REG_IDX_W-1:0] reg_idx_d;
    logic                 reg_we_d;
    logic                 done_d;
    logic                 wb_en_d;
    logic [DATA_W-1:0]    wb_value_d;
    logic [DATA_W-1:0]    span;

    function automatic logic [REG_IDX_W-1:0] lowest_idx(input logic [REG_CNT-1:0] l);
        logic [REG_IDX_W-1:0] r;
        r = '0;
        for (int i = REG_CNT - 1; i >= 0; i--) begin
            if (l[i]) r = REG_IDX_W'(i);
        end
        return r;
    endfunction

    // Byte span of the whole transfer block: 4 * popcount.
    function automatic logic [DATA_W-1:0] block_span(input logic [REG_CNT-1:0] l);
        logic [DATA_W-1:0] c;
        c = '0;
        for (int i = 0; i < REG_CNT; i++) begin
            c = c + DATA_W'(l[i]);
        end
        return c << 2;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            list_q   <= '0;
            base_q   <= '0;
            p_q      <= 1'b0;
            u_q      <= 1'b0;
            w_q      <= 1'b0;
            wins_q   <= 1'b0;
            busy     <= 1'b0;
            mem_req  <= 1'b0;
            mem_rw   <= 1'b0;
            mem_addr <= '0;
            reg_idx  <= '0;
            reg_we   <= 1'b0;
            done     <= 1'b0;
            wb_en    <= 1'b0;
            wb_value <= '0;
        end else begin
            state_q  <= state_d;
            list_q   <= list_d;
            base_q   <= base_d;
            p_q      <= p_d;
            u_q      <= u_d;
            w_q      <= w_d;
            wins_q   <= wins_d;
            busy     <= busy_d;
            mem_req  <= mem_req_d;
            mem_rw   <= mem_rw_d;
            mem_addr <= mem_addr_d;
            reg_idx  <= reg_idx_d;
            reg_we   <= reg_we_d;
            done     <= done_d;
            wb_en    <= wb_en_d;
            wb_value <= wb_value_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        list_d     = list_q;
        base_d     = base_q;
        p_d        = p_q;
        u_d        = u_q;
        w_d        = w_q;
        wins_d     = wins_q;
        mem_req_d  = 1'b0;
        mem_rw_d   = mem_rw;
        mem_addr_d = mem_addr;
        reg_idx_d  = reg_idx;
        reg_we_d   = 1'b0;
        done_d     = 1'b0;
        wb_en_d    = 1'b0;
        wb_value_d = wb_value;
        span       = block_span(list_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SETUP;
                    list_d   = reg_list;
                    base_d   = base_addr;
                    p_d      = p_bit;
                    u_d      = u_bit;
                    w_d      = w_bit;
                    mem_rw_d = l_bit;
                    wins_d   = l_bit & reg_list[rn_idx];
                end
            end
            S_SETUP: begin
                // Empty list gives span 0, so wb_value naturally equals base.
                wb_value_d = u_q ? (base_q + span) : (base_q - span);
                if (list_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    wb_en_d = w_q & ~(WINS_EN & wins_q);
                end else begin
                    state_d   = S_ACCESS;
                    mem_req_d = 1'b1;
                    reg_idx_d = lowest_idx(list_q);
                    if (u_q) begin
                        mem_addr_d = p_q ? (base_q + WORD) : base_q;
                    end else begin
                        mem_addr_d = p_q ? (base_q - span) : (base_q - span + WORD);
                    end
                end
            end
            S_ACCESS: begin
                if (mem_done) begin
                    state_d  = S_NEXT;
                    reg_we_d = mem_rw;
                    list_d   = list_q & ~(REG_CNT'(1) << reg_idx);
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            S_NEXT: begin
                if (list_q != '0) begin
                    state_d    = S_ACCESS;
                    mem_req_d  = 1'b1;
                    reg_idx_d  = lowest_idx(list_q);
                    mem_addr_d = mem_addr + WORD;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    wb_en_d = w_q & ~(WINS_EN & wins_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Self-checking bench for lsm_sequencer: directed vector table, randomized operations
// against a transfer-list reference model, and a mid-operation reset sequence.
module tb_lsm_sequencer;

`ifdef LSM_BASE_LOAD_WINS_EN
    localparam logic WINS = 1'b1;
`else
    localparam logic WINS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic [3:0]  rn_idx;
    logic        p_bit, u_bit, w_bit, l_bit;
    logic        mem_done;
    logic        busy, mem_req, mem_rw, reg_we, done, wb_en;
    logic [31:0] mem_addr, wb_value;
    logic [3:0]  reg_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] list;
        logic [31:0] base;
        logic [3:0]  rn;
        logic        p, u, w, l;
        int          n;
        logic [31:0] first;
        logic [31:0] wb;
        logic        wbe;
    } vec_t;

    lsm_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .reg_list(reg_list),
        .base_addr(base_addr), .rn_idx(rn_idx), .p_bit(p_bit), .u_bit(u_bit),
        .w_bit(w_bit), .l_bit(l_bit), .mem_done(mem_done), .busy(busy),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .reg_idx(reg_idx),
        .reg_we(reg_we), .done(done), .wb_en(wb_en), .wb_value(wb_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the block of n words sits at the lowest address implied by the mode,
    // and registers map onto it in ascending order.
    function automatic vec_t model(input logic [15:0] list, input logic [31:0] base,
                                   input logic [3:0] rn, input logic p, input logic u,
                                   input logic w, input logic l);
        vec_t v;
        logic [31:0] bytes;
        v.list = list; v.base = base; v.rn = rn;
        v.p = p; v.u = u; v.w = w; v.l = l;
        v.n = $countones(list);
        bytes = 32'(v.n) * 32'd4;
        if (u) v.first = p ? base + 32'd4 : base;
        else   v.first = p ? base - bytes : base - bytes + 32'd4;
        v.wb  = u ? base + bytes : base - bytes;
        v.wbe = w && !(WINS && l && list[rn]);
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_reg_we"},  32'(reg_we),  32'd0);
    endtask

    // Runs one instruction; fixed_dly < 0 selects random mem_done latency per transfer.
    task automatic run_op(input vec_t v, input int fixed_dly);
        int pos;
        int d;
        logic [31:0] exp_addr;
        reg_list  = v.list; base_addr = v.base; rn_idx = v.rn;
        p_bit = v.p; u_bit = v.u; w_bit = v.w; l_bit = v.l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("setup_busy", 32'(busy), 32'd1);
        chk("setup_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        pos = 0;
        for (int k = 0; k < v.n; k++) begin
            while (!v.list[pos]) pos++;
            exp_addr = v.first + 32'(k) * 32'd4;
            chk("acc_req", 32'(mem_req), 32'd1);
            chk("acc_addr", mem_addr, exp_addr);
            chk("acc_idx", 32'(reg_idx), 32'(pos));
            chk("acc_rw", 32'(mem_rw), 32'(v.l));
            chk("acc_we", 32'(reg_we), 32'd0);
            d = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
            for (int j = 0; j < d; j++) begin
                start = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("hold_req", 32'(mem_req), 32'd1);
                chk("hold_addr", mem_addr, exp_addr);
                chk("hold_busy", 32'(busy), 32'd1);
            end
            start = 1'b0;
            mem_done = 1'b1;
            @(negedge clk);
            mem_done = 1'b0;
            chk("next_req", 32'(mem_req), 32'd0);
            chk("next_we", 32'(reg_we), 32'(v.l));
            chk("next_idx", 32'(reg_idx), 32'(pos));
            pos++;
            if (fixed_dly < 0) mem_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            mem_done = 1'b0;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_req", 32'(mem_req), 32'd0);
        chk("done_wb_en", 32'(wb_en), 32'(v.wbe));
        chk("done_wb_value", wb_value, v.wb);
        @(negedge clk);
        chk("after_done", 32'(done), 32'd0);
        chk("after_wb_en", 32'(wb_en), 32'd0);
        chk("after_busy", 32'(busy), 32'd0);
    endtask

    vec_t tbl[7];
    vec_t rv;
    logic [15:0] rl;

    initial begin
        reset = 1'b1; start = 1'b0; mem_done = 1'b0;
        reg_list = '0; base_addr = '0; rn_idx = '0;
        p_bit = 1'b0; u_bit = 1'b0; w_bit = 1'b0; l_bit = 1'b0;

        //            list      base          rn   p     u     w     l     n  first         wb            wbe
        tbl[0] = '{16'h000F, 32'h0000_0100, 4'd13, 1'b0, 1'b1, 1'b1, 1'b1, 4, 32'h0000_0100, 32'h0000_0110, 1'b1};
        tbl[1] = '{16'h8001, 32'h0000_0200, 4'd1,  1'b1, 1'b0, 1'b1, 1'b0, 2, 32'h0000_01F8, 32'h0000_01F8, 1'b1};
        tbl[2] = '{16'h0110, 32'h0000_0040, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 2, 32'h0000_0044, 32'h0000_0048, 1'b0};
        tbl[3] = '{16'h0110, 32'h0000_0040, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2, 32'h0000_003C, 32'h0000_0038, 1'b1};
        tbl[4] = '{16'h0000, 32'h0000_1234, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1, 0, 32'h0000_0000, 32'h0000_1234, 1'b1};
        tbl[5] = '{16'h0006, 32'h0000_0080, 4'd2,  1'b0, 1'b1, 1'b1, 1'b1, 2, 32'h0000_0080, 32'h0000_0088, ~WINS};
        tbl[6] = '{16'h0003, 32'h0000_0004, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};

        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        chk("in_reset_addr", mem_addr, 32'd0);
        chk("in_reset_wb", wb_value, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        check_idle_outputs("idle_mem_done");

        for (int i = 0; i < 7; i++) run_op(tbl[i], 0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0:       rl = 16'h0000;
                1:       rl = 16'h0001 << $urandom_range(0, 15);
                2:       rl = 16'hFFFF;
                default: rl = 16'($urandom);
            endcase
            rv = model(rl, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_op(rv, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // mem_done delayed 3 cycles, then reset during the second access.
        reg_list = 16'h000F; base_addr = 32'h100; rn_idx = 4'd13;
        p_bit = 1'b0; u_bit = 1'b1; w_bit = 1'b1; l_bit = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_seq_req", 32'(mem_req), 32'd1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("rst_seq_hold_req", 32'(mem_req), 32'd1);
            chk("rst_seq_hold_addr", mem_addr, 32'h100);
        end
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("rst_seq_we", 32'(reg_we), 32'd1);
        @(negedge clk);
        chk("rst_seq_req2", 32'(mem_req), 32'd1);
        chk("rst_seq_addr2", mem_addr, 32'h104);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        chk("mid_reset_rw", 32'(mem_rw), 32'd0);
        chk("mid_reset_addr", mem_addr, 32'd0);
        chk("mid_reset_idx", 32'(reg_idx), 32'd0);
        chk("mid_reset_wb_en", 32'(wb_en), 32'd0);
        chk("mid_reset_wb", wb_value, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_mid_reset");

        run_op(tbl[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
